// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive controller.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [5:0] PRESCALE_8       = 6'd8;
  localparam logic [5:0] PRESCALE_16      = 6'd16;
  localparam logic [5:0] PRESCALE_32      = 6'd32;
  localparam logic [5:0] PRESCALE_DEFAULT = PRESCALE_16;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Unsupported oversampling ratios fall back to the default.
  function automatic logic [5:0] legal_prescale(input logic [5:0] p);
    case (p)
      PRESCALE_8, PRESCALE_16, PRESCALE_32: return p;
      default:                              return PRESCALE_DEFAULT;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_edge_bit_counter.sv
// Oversampling edge counter and bit counter; bit_done strobes on the last
// edge of each bit period.
module edge_bit_counter #(
  parameter int unsigned PRESCALE_MAX = 32,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned EDGE_W       = $clog2(PRESCALE_MAX),
  parameter int unsigned BIT_W        = $clog2(DATA_WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              enable,
  input  logic              bit_inc,
  input  logic [EDGE_W-1:0] prescale_last,
  output logic [EDGE_W-1:0] edge_cnt,
  output logic [BIT_W-1:0]  bit_cnt,
  output logic              bit_done
);

  assign bit_done = enable && (edge_cnt == prescale_last);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (enable) begin
      if (bit_done) begin
        edge_cnt <= '0;
        if (bit_inc) bit_cnt <= bit_cnt + 1'b1;
      end else begin
        edge_cnt <= edge_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: start detect, data/parity/stop assembly.
// Optional parity checker built when UART_RX_PARITY_EN is defined.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int unsigned PRESCALE_MAX = 32,
  parameter int unsigned DATA_WIDTH   = 8
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic                            RX_IN,
  input  logic [5:0]                      Prescale,
  input  logic                            PAR_EN,
  input  logic                            PAR_TYP,
  input  logic                            sampled_bit,
  output logic                            data_samp_en,
  output logic [$clog2(PRESCALE_MAX)-1:0] edge_cnt,
  output logic [DATA_WIDTH-1:0]           P_DATA,
  output logic                            data_valid,
  output logic                            par_err,
  output logic                            stp_err,
  output logic                            busy
);

  localparam int unsigned EDGE_W = $clog2(PRESCALE_MAX);
  localparam int unsigned BIT_W  = $clog2(DATA_WIDTH);

  state_t                state_q, state_d;
  logic [5:0]            prescale_q;
  logic [EDGE_W-1:0]     prescale_last;
  logic [BIT_W-1:0]      bit_cnt;
  logic                  bit_done;
  logic                  last_bit;
  logic                  start_det;
  logic                  frame_par_bad;
  logic [DATA_WIDTH-1:0] shift_q;

  assign start_det     = (state_q == IDLE) && !RX_IN;
  assign prescale_last = EDGE_W'(prescale_q - 6'd1);
  assign last_bit      = (bit_cnt == BIT_W'(DATA_WIDTH - 1));
  assign busy          = (state_q != IDLE);
  assign data_samp_en  = busy;

  edge_bit_counter #(
    .PRESCALE_MAX (PRESCALE_MAX),
    .DATA_WIDTH   (DATA_WIDTH)
  ) u_counter (
    .clk           (CLK),
    .rst           (RST),
    .clear         (state_q == IDLE),
    .enable        (busy),
    .bit_inc       (state_q == DATA),
    .prescale_last (prescale_last),
    .edge_cnt      (edge_cnt),
    .bit_cnt       (bit_cnt),
    .bit_done      (bit_done)
  );

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (!RX_IN) state_d = START;
      START: if (bit_done) state_d = sampled_bit ? IDLE : DATA;
      DATA: begin
        if (bit_done && last_bit) begin
`ifdef UART_RX_PARITY_EN
          state_d = PAR_EN ? PARITY : STOP;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (bit_done) state_d = STOP;
`endif
      STOP:  if (bit_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  logic par_flag_q;
  logic par_err_q;
  logic parity_exp;

  assign parity_exp    = (^shift_q) ^ (PAR_TYP == PAR_ODD);
  assign frame_par_bad = par_flag_q;
  assign par_err       = par_err_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      par_flag_q <= 1'b0;
      par_err_q  <= 1'b0;
    end else begin
      par_err_q <= 1'b0;
      if (start_det)
        par_flag_q <= 1'b0;
      else if (bit_done && state_q == PARITY && sampled_bit != parity_exp)
        par_flag_q <= 1'b1;
      if (bit_done && state_q == STOP)
        par_err_q <= par_flag_q;
    end
  end
`else
  logic unused_par;
  assign unused_par    = PAR_EN ^ PAR_TYP;
  assign frame_par_bad = 1'b0;
  assign par_err       = 1'b0;
`endif

  // Prescale is captured only at start detect so mid-frame changes are ignored.
  always_ff @(posedge CLK) begin
    if (RST) begin
      prescale_q <= PRESCALE_DEFAULT;
      shift_q    <= '0;
      P_DATA     <= '0;
      data_valid <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      stp_err    <= 1'b0;
      if (start_det) prescale_q <= legal_prescale(Prescale);
      if (bit_done) begin
        case (state_q)
          DATA: shift_q <= {sampled_bit, shift_q[DATA_WIDTH-1:1]};
          STOP: begin
            stp_err <= ~sampled_bit;
            if (sampled_bit && !frame_par_bad) begin
              P_DATA     <= shift_q;
              data_valid <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl with a mid-bit sampler model.
module tb_uart_rx_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RX_IN = 1'b1;
  logic [5:0] Prescale = 6'd16;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       sampled_bit = 1'b1;
  logic       data_samp_en, data_valid, par_err, stp_err, busy;
  logic [4:0] edge_cnt;
  logic [7:0] P_DATA;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int cur_p = 16;

  typedef struct {
    logic [2:0] kind;
    logic [7:0] data;
    int         lo;
    int         hi;
  } exp_t;
  exp_t sb[$];

  uart_rx_ctrl #(.PRESCALE_MAX(32), .DATA_WIDTH(8)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .RX_IN        (RX_IN),
    .Prescale     (Prescale),
    .PAR_EN       (PAR_EN),
    .PAR_TYP      (PAR_TYP),
    .sampled_bit  (sampled_bit),
    .data_samp_en (data_samp_en),
    .edge_cnt     (edge_cnt),
    .P_DATA       (P_DATA),
    .data_valid   (data_valid),
    .par_err      (par_err),
    .stp_err      (stp_err),
    .busy         (busy)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Sampler model: capture the line at mid-bit and hold to the boundary.
  always @(negedge CLK)
    if (data_samp_en && int'(edge_cnt) == cur_p / 2) sampled_bit <= RX_IN;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (!RST) begin
      if (data_valid || par_err || stp_err) begin
        if (sb.size() == 0) begin
          check("unexpected_pulse", {29'd0, data_valid, par_err, stp_err}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("pulse_kind", {29'd0, data_valid, par_err, stp_err}, {29'd0, e.kind});
          check("p_data", {24'd0, P_DATA}, {24'd0, e.data});
          check("pulse_cycle_in_window", {31'd0, (cyc >= e.lo && cyc <= e.hi)}, 32'd1);
        end
      end else if (sb.size() != 0 && cyc > sb[0].hi) begin
        check("missing_pulse", 32'd0, {29'd0, sb[0].kind});
        void'(sb.pop_front());
      end
    end
  end

  task automatic drive_bit(input logic b, input int n);
    RX_IN = b;
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // p: effective (latched) ratio; pres: value on the Prescale port.
  task automatic send_frame(input int p, input logic [5:0] pres, input logic [7:0] data,
                            input bit par_on, input bit par_bit, input bit stop_bit,
                            input logic [2:0] kind, input logic [7:0] exp_data);
    exp_t e;
    int n;
    n = par_on ? 11 : 10;
    e.kind = kind;
    e.data = exp_data;
    e.lo   = cyc + n * p + 1;
    e.hi   = e.lo + 1;
    sb.push_back(e);
    cur_p    = p;
    Prescale = pres;
    drive_bit(1'b0, p);
    for (int i = 0; i < 8; i++) drive_bit(data[i], p);
    if (par_on) drive_bit(par_bit, p);
    drive_bit(stop_bit, p);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_samp_en"}, {31'd0, data_samp_en}, 32'd0);
    check({tag, "_edge_cnt"}, {27'd0, edge_cnt}, 32'd0);
    check({tag, "_p_data"}, {24'd0, P_DATA}, 32'd0);
    check({tag, "_pulses"}, {29'd0, data_valid, par_err, stp_err}, 32'd0);
  endtask

  initial begin
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check_reset_outputs("reset");
    RST = 1'b0;
    drive_bit(1'b1, 4);

    send_frame(16, 6'd16, 8'hA5, 0, 0, 1, 3'b100, 8'hA5);
    drive_bit(1'b1, 4);

`ifdef UART_RX_PARITY_EN
    PAR_EN = 1'b1;
    PAR_TYP = 1'b0;
    send_frame(16, 6'd16, 8'h3C, 1, 0, 1, 3'b100, 8'h3C);
    drive_bit(1'b1, 4);
    send_frame(16, 6'd16, 8'h3C, 1, 1, 1, 3'b010, 8'h3C);
    drive_bit(1'b1, 4);
    PAR_TYP = 1'b1;
    send_frame(16, 6'd16, 8'h81, 1, 1, 1, 3'b100, 8'h81);
    drive_bit(1'b1, 4);
`else
    PAR_EN = 1'b1;
    PAR_TYP = 1'b1;
    send_frame(16, 6'd16, 8'h3C, 0, 0, 1, 3'b100, 8'h3C);
    drive_bit(1'b1, 4);
    send_frame(16, 6'd16, 8'h81, 0, 0, 1, 3'b100, 8'h81);
    drive_bit(1'b1, 4);
`endif
    PAR_EN = 1'b0;
    PAR_TYP = 1'b0;

    send_frame(8, 6'd8, 8'h55, 0, 0, 0, 3'b001, 8'h81);
    drive_bit(1'b1, 4);

    cur_p = 16;
    Prescale = 6'd16;
    drive_bit(1'b0, 3);
    drive_bit(1'b1, 2);
    check("glitch_busy_in_start", {31'd0, busy}, 32'd1);
    drive_bit(1'b1, 13);
    check("glitch_busy_after", {31'd0, busy}, 32'd0);
    check("glitch_edge_cnt_after", {27'd0, edge_cnt}, 32'd0);

    send_frame(8, 6'd8, 8'h01, 0, 0, 1, 3'b100, 8'h01);
    send_frame(8, 6'd8, 8'hFF, 0, 0, 1, 3'b100, 8'hFF);
    drive_bit(1'b1, 4);

    send_frame(16, 6'd12, 8'h96, 0, 0, 1, 3'b100, 8'h96);
    drive_bit(1'b1, 4);

    cur_p = 8;
    Prescale = 6'd8;
    drive_bit(1'b0, 8);
    for (int i = 0; i < 4; i++) drive_bit(i[0] ? 1'b1 : 1'b1, 8);
    drive_bit(1'b0, 4);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    RX_IN = 1'b1;
    check_reset_outputs("midframe_reset");
    drive_bit(1'b1, 100);
    send_frame(8, 6'd8, 8'h7E, 0, 0, 1, 3'b100, 8'h7E);
    drive_bit(1'b1, 20);

    check("scoreboard_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
